float_mul_pipe: RTL and testbench
=================================

// Module: float_mul_pipe
// PURPOSE
//  Pipelined, parametrised IEEE-style floating-point multiplier with valid/ready handshake.
//  - Fixed 3-stage pipeline, one result per cycle; replaces combinational float_mul in matmul datapaths.
//  - Selectable rounding; 0*inf yields NaN; exception flags reported.
//  - Opaque tag is carried alongside each operand pair so accumulators can match results.
// PARAMETERS
//  EXP_WIDTH   8    exponent field width
//  MAN_WIDTH   23   stored mantissa (fraction) width
//  BIAS        127  exponent bias, normally 2^(EXP_WIDTH-1)-1
//  TAG_WIDTH   4    width of sideband tag, must be >= 1
// PORTS  (W = 1+EXP_WIDTH+MAN_WIDTH)
//  clk        in   1          clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          operand pair valid
//  in_ready   out  1          block accepts operands this cycle
//  lhs        in   W          operand A
//  rhs        in   W          operand B
//  rnd_mode   in   1          0 = truncate toward zero, 1 = round-to-nearest-even; sampled with operands
//  in_tag     in   TAG_WIDTH  sideband tag, returned unchanged with the result
//  out_valid  out  1          result valid
//  out_ready  in   1          consumer accepts result
//  out        out  W          product
//  out_tag    out  TAG_WIDTH  tag of this result
//  flag_inv   out  1          invalid: NaN input or 0*inf
//  flag_ovf   out  1          overflow to infinity
//  flag_unf   out  1          result flushed to zero (finite nonzero operands)
// BEHAVIOUR
//  Reset
//   - rst_n low asynchronously clears all stage valid bits.
//   - out_valid, out, out_tag and all flags are 0 during and after reset; in_ready is 1 after reset.
//   - Reset mid-operation discards every in-flight item; nothing reappears after release.
//  Handshake
//   - Transfer in on in_valid&in_ready; transfer out on out_valid&out_ready.
//   - out, out_tag and flags hold stable while out_valid&!out_ready.
//  Pipeline
//   - Stage k advances when it is empty or when stage k+1 advances; bubbles collapse.
//   - Latency is exactly 3 cycles with no stall: operands accepted at edge N appear with out_valid at N+3.
//   - in_ready = !s1_valid | s1_advance (combinational from out_ready); full throughput with out_ready held 1.
//   - Up to 3 items in flight. With out_ready low the pipe fills; in_ready drops once all 3 stages hold data.
//  Stage S1: unpack and classify
//   - Detect zero, inf, NaN; subnormal operands are treated as zero (flush-to-zero).
//   - Form exponent sum e = eA + eB - BIAS in EXP_WIDTH+2 signed bits.
//  Stage S2: multiply
//   - Full (MAN_WIDTH+1)x(MAN_WIDTH+1) unsigned product of mantissas with hidden 1s.
//  Stage S3: normalise, round, pack
//   - If product MSB is set, shift right 1 and increment e.
//   - Guard bit = first dropped bit; sticky = OR of the rest.
//   - RNE: increment when guard & (sticky | lsb). Mantissa carry-out renormalises and increments e.
//   - e >= 2^EXP_WIDTH-1 after rounding gives signed inf, flag_ovf=1.
//   - e <= 0 gives signed zero, flag_unf=1.
//  Specials (priority order)
//   1. Any NaN, or zero*inf: canonical NaN {0, all-1 exp, all-1 man}, flag_inv=1.
//   2. Any inf: inf with sign = sA^sB.
//   3. Any zero: zero with sign = sA^sB.
//   - Flags are 0 for specials other than case 1.
//  Sign is always sA^sB except for NaN.
// TESTING
//  1. 0x40400000*0x40000000 (3*2), RNE, tag 5 -> 0x40C00000, tag 5, no flags, out_valid exactly 3 cycles after accept.
//  2. 0x3FC00000*0x3F800001 (exact tie) -> RNE 0x3FC00002; truncate 0x3FC00001.
//  3. 0x7F000000*0x40000000 -> 0x7F800000, flag_ovf=1.
//     0x00800000*0x00800000 -> 0x00000000, flag_unf=1.
//  4. 0x00000000*0x7F800000 -> 0x7FFFFFFF, flag_inv=1.
//     0xFF800000*0x40000000 -> 0xFF800000, no flags.
//  5. Stream 8 tagged pairs with out_ready toggling randomly -> all 8 results in order, none lost or duplicated.
//     in_ready low only while 3 items are held; outputs stable while stalled.
//  6. Pull rst_n low with 3 items in flight -> out_valid falls immediately.
//     After release, a new pair emerges at +3 cycles and no stale result appears.

Source files
------------

// File: rtl/float_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake.
// Ports: clk, rst_n (async low); in_valid/in_ready, lhs, rhs, rnd_mode, in_tag;
//        out_valid/out_ready, out, out_tag, flag_inv, flag_ovf, flag_unf.
module float_mul_pipe #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int BIAS      = 127,
    parameter int TAG_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]   lhs,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]   rhs,
    input  logic                           rnd_mode,
    input  logic [TAG_WIDTH-1:0]           in_tag,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_WIDTH+MAN_WIDTH:0]   out,
    output logic [TAG_WIDTH-1:0]           out_tag,
    output logic                           flag_inv,
    output logic                           flag_ovf,
    output logic                           flag_unf
);

    localparam int EW  = EXP_WIDTH;
    localparam int MW  = MAN_WIDTH;
    localparam int W   = 1 + EW + MW;
    localparam int MW1 = MW + 1;
    localparam int PW  = 2 * MW1;
    localparam int EE  = EW + 2;

    localparam logic signed [EE-1:0] EMAX = EE'((1 << EW) - 1);
    localparam logic signed [EE-1:0] EZERO = '0;

    // Handshake: a stage advances when empty or when its successor advances.
    logic adv1, adv2, adv3;

    // Stage 1 registers
    logic                  s1_valid_q;
    logic                  s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
    logic signed [EE-1:0]  s1_exp_q;
    logic [MW1-1:0]        s1_ma_q, s1_mb_q;
    logic                  s1_rnd_q;
    logic [TAG_WIDTH-1:0]  s1_tag_q;

    // Stage 2 registers
    logic                  s2_valid_q;
    logic                  s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;
    logic signed [EE-1:0]  s2_exp_q;
    logic [PW-1:0]         s2_prod_q;
    logic                  s2_rnd_q;
    logic [TAG_WIDTH-1:0]  s2_tag_q;

    // Stage 3 (output) registers
    logic                  s3_valid_q;
    logic [W-1:0]          s3_out_q;
    logic [TAG_WIDTH-1:0]  s3_tag_q;
    logic                  s3_inv_q, s3_ovf_q, s3_unf_q;

    assign adv3     = !s3_valid_q || out_ready;
    assign adv2     = !s2_valid_q || adv3;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;

    assign out_valid = s3_valid_q;
    assign out       = s3_out_q;
    assign out_tag   = s3_tag_q;
    assign flag_inv  = s3_inv_q;
    assign flag_ovf  = s3_ovf_q;
    assign flag_unf  = s3_unf_q;

    // ---------------- Stage 1: unpack and classify ----------------
    logic                 sa, sb;
    logic [EW-1:0]        ea, eb;
    logic [MW-1:0]        fa, fb;
    logic                 za, zb, ia, ib, na, nb;
    logic                 s1_nan_d, s1_inf_d, s1_zero_d;
    logic signed [EE-1:0] s1_exp_d;

    assign {sa, ea, fa} = lhs;
    assign {sb, eb, fb} = rhs;

    // Zero exponent covers subnormals, which are flushed to zero.
    assign za = (ea == '0);
    assign zb = (eb == '0);
    assign ia = (ea == '1) && (fa == '0);
    assign ib = (eb == '1) && (fb == '0);
    assign na = (ea == '1) && (fa != '0);
    assign nb = (eb == '1) && (fb != '0);

    assign s1_nan_d  = na || nb || (za && ib) || (ia && zb);
    assign s1_inf_d  = ia || ib;
    assign s1_zero_d = za || zb;
    assign s1_exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb})
                     - $signed(EE'(BIAS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_nan_q   <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_ma_q    <= '0;
            s1_mb_q    <= '0;
            s1_rnd_q   <= 1'b0;
            s1_tag_q   <= '0;
        end else if (adv1) begin
            s1_valid_q <= in_valid;
            s1_sign_q  <= sa ^ sb;
            s1_nan_q   <= s1_nan_d;
            s1_inf_q   <= s1_inf_d;
            s1_zero_q  <= s1_zero_d;
            s1_exp_q   <= s1_exp_d;
            s1_ma_q    <= {1'b1, fa};
            s1_mb_q    <= {1'b1, fb};
            s1_rnd_q   <= rnd_mode;
            s1_tag_q   <= in_tag;
        end
    end

    // ---------------- Stage 2: mantissa multiply ----------------
    logic [PW-1:0] s2_prod_d;

    assign s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_nan_q   <= 1'b0;
            s2_inf_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_prod_q  <= '0;
            s2_rnd_q   <= 1'b0;
            s2_tag_q   <= '0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            s2_sign_q  <= s1_sign_q;
            s2_nan_q   <= s1_nan_q;
            s2_inf_q   <= s1_inf_q;
            s2_zero_q  <= s1_zero_q;
            s2_exp_q   <= s1_exp_q;
            s2_prod_q  <= s2_prod_d;
            s2_rnd_q   <= s1_rnd_q;
            s2_tag_q   <= s1_tag_q;
        end
    end

    // ---------------- Stage 3: normalise, round, pack ----------------
    logic [PW-2:0]        norm;
    logic signed [EE-1:0] exp_n, exp_r;
    logic [MW-1:0]        man_t;
    logic                 guard, sticky, inc;
    logic [MW:0]          man_r;
    logic [W-1:0]         s3_out_d;
    logic                 s3_inv_d, s3_ovf_d, s3_unf_d;

    always_comb begin
        // Product of two [1,2) values lies in [1,4); align leading 1 to PW-2.
        norm = s2_prod_q[PW-1] ? s2_prod_q[PW-1:1] : s2_prod_q[PW-2:0];
        exp_n = s2_exp_q
              + $signed({{(EE-1){1'b0}}, s2_prod_q[PW-1]});
        man_t  = norm[PW-3 -: MW];
        guard  = norm[PW-3-MW];
        sticky = |norm[PW-4-MW:0];
        inc    = s2_rnd_q && guard && (sticky || man_t[0]);
        man_r  = {1'b0, man_t} + {{MW{1'b0}}, inc};
        // Carry-out means mantissa wrapped to 1.0; low bits are already zero.
        exp_r  = exp_n + $signed({{(EE-1){1'b0}}, man_r[MW]});

        s3_out_d = '0;
        s3_inv_d = 1'b0;
        s3_ovf_d = 1'b0;
        s3_unf_d = 1'b0;
        if (s2_nan_q) begin
            s3_out_d = {1'b0, {EW{1'b1}}, {MW{1'b1}}};
            s3_inv_d = 1'b1;
        end else if (s2_inf_q) begin
            s3_out_d = {s2_sign_q, {EW{1'b1}}, {MW{1'b0}}};
        end else if (s2_zero_q) begin
            s3_out_d = {s2_sign_q, {(W-1){1'b0}}};
        end else if (exp_r >= EMAX) begin
            s3_out_d = {s2_sign_q, {EW{1'b1}}, {MW{1'b0}}};
            s3_ovf_d = 1'b1;
        end else if (exp_r <= EZERO) begin
            s3_out_d = {s2_sign_q, {(W-1){1'b0}}};
            s3_unf_d = 1'b1;
        end else begin
            s3_out_d = {s2_sign_q, exp_r[EW-1:0], man_r[MW-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid_q <= 1'b0;
            s3_out_q   <= '0;
            s3_tag_q   <= '0;
            s3_inv_q   <= 1'b0;
            s3_ovf_q   <= 1'b0;
            s3_unf_q   <= 1'b0;
        end else if (adv3) begin
            s3_valid_q <= s2_valid_q;
            s3_out_q   <= s3_out_d;
            s3_tag_q   <= s2_tag_q;
            s3_inv_q   <= s3_inv_d;
            s3_ovf_q   <= s3_ovf_d;
            s3_unf_q   <= s3_unf_d;
        end
    end

endmodule

// File: tb/tb_float_mul_pipe.sv
// Directed self-checking bench for float_mul_pipe (single precision, 4-bit tag).
// Checks reset, arithmetic corner cases, backpressure streaming and mid-flight reset.
module tb_float_mul_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic        rnd_mode;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [3:0]  out_tag;
    logic        flag_inv;
    logic        flag_ovf;
    logic        flag_unf;

    int checks   = 0;
    int failures = 0;

    float_mul_pipe #(
        .EXP_WIDTH (8),
        .MAN_WIDTH (23),
        .BIAS      (127),
        .TAG_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lhs       (lhs),
        .rhs       (rhs),
        .rnd_mode  (rnd_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_tag   (out_tag),
        .flag_inv  (flag_inv),
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp_v);
        end
    endtask

    // One operand pair through an empty pipe with out_ready held high.
    task automatic run_vec(input string nm, input logic [31:0] a,
                           input logic [31:0] b, input logic rm,
                           input logic [3:0] tg, input logic [31:0] eo,
                           input logic [2:0] ef);
        int lat;
        @(negedge clk);
        lhs = a; rhs = b; rnd_mode = rm; in_tag = tg;
        in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'd3);
        chk({nm, "_out"}, out, eo);
        chk({nm, "_tag"}, 32'(out_tag), 32'(tg));
        chk({nm, "_flags"}, 32'({flag_inv, flag_ovf, flag_unf}), 32'(ef));
        @(negedge clk);
        chk({nm, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    logic [31:0] vec [8];
    int          tx, rx, occ;
    logic        held, in_x, out_x;
    logic [31:0] hold_out;
    logic [3:0]  hold_tag;

    initial begin
        vec[0] = 32'h3F800000; vec[1] = 32'h40490FDB;
        vec[2] = 32'hC0000000; vec[3] = 32'h3E800000;
        vec[4] = 32'h42F60000; vec[5] = 32'hBF400000;
        vec[6] = 32'h01000000; vec[7] = 32'h7E000000;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        lhs = '0; rhs = '0; rnd_mode = 1'b0; in_tag = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", out, 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_flags", 32'({flag_inv, flag_ovf, flag_unf}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        run_vec("mul3x2", 32'h40400000, 32'h40000000, 1'b1, 4'd5,
                32'h40C00000, 3'b000);
        run_vec("tie_rne", 32'h3FC00000, 32'h3F800001, 1'b1, 4'd1,
                32'h3FC00002, 3'b000);
        run_vec("tie_trunc", 32'h3FC00000, 32'h3F800001, 1'b0, 4'd2,
                32'h3FC00001, 3'b000);
        run_vec("ovf", 32'h7F000000, 32'h40000000, 1'b1, 4'd3,
                32'h7F800000, 3'b010);
        run_vec("unf", 32'h00800000, 32'h00800000, 1'b1, 4'd4,
                32'h00000000, 3'b001);
        run_vec("zero_inf", 32'h00000000, 32'h7F800000, 1'b1, 4'd6,
                32'h7FFFFFFF, 3'b100);
        run_vec("neg_inf", 32'hFF800000, 32'h40000000, 1'b1, 4'd7,
                32'hFF800000, 3'b000);
        run_vec("nan_in", 32'h7FC00000, 32'h3F800000, 1'b1, 4'd8,
                32'h7FFFFFFF, 3'b100);
        run_vec("subn_flush", 32'h80000001, 32'h40000000, 1'b1, 4'd9,
                32'h80000000, 3'b000);

        // Stream 8 pairs (2.0 * x) under random backpressure.
        tx = 0; rx = 0; occ = 0; held = 1'b0;
        hold_out = '0; hold_tag = '0;
        for (int cyc = 0; cyc < 400 && rx < 8; cyc++) begin
            @(negedge clk);
            if (held) begin
                chk("s5_hold_out", out, hold_out);
                chk("s5_hold_tag", 32'(out_tag), 32'(hold_tag));
            end
            out_ready = (cyc < 6) ? 1'b0 : 1'($urandom_range(0, 1));
            in_valid = (tx < 8);
            if (tx < 8) begin
                lhs = 32'h40000000; rhs = vec[tx];
                in_tag = 4'(tx); rnd_mode = 1'b1;
            end
            #1;
            chk("s5_in_ready", 32'(in_ready),
                32'(!(occ == 3 && !out_ready)));
            in_x  = in_valid && in_ready;
            out_x = out_valid && out_ready;
            if (out_x) begin
                chk("s5_out", out, vec[rx] + 32'h00800000);
                chk("s5_tag", 32'(out_tag), 32'(rx));
                rx++;
            end
            held     = out_valid && !out_ready;
            hold_out = out;
            hold_tag = out_tag;
            if (in_x) tx++;
            occ = occ + int'(in_x) - int'(out_x);
        end
        chk("s5_all_received", 32'(rx), 32'd8);
        @(negedge clk);
        in_valid = 1'b0;

        // Fill the pipe, then reset asynchronously with 3 items in flight.
        out_ready = 1'b0;
        lhs = 32'h40400000; rhs = 32'h40000000;
        rnd_mode = 1'b1; in_tag = 4'd9; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_out_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out", out, 32'd0);
        chk("midrst_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_no_stale", 32'(out_valid), 32'd0);
        run_vec("after_rst", 32'h3F800000, 32'h40400000, 1'b1, 4'd3,
                32'h40400000, 3'b000);
        repeat (3) begin
            @(negedge clk);
            chk("after_rst_idle", 32'(out_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
